// File: rtl/arc4_crack_ctrl.sv
// ARC4 key-search controller.
// Steps candidate keys KEY_START, KEY_START+KEY_STEP, ... up to KEY_LAST through
// one ARC4 engine. After each decryption it takes over the PT memory read port
// and checks the length-prefixed plaintext for printable ASCII (8'h20..8'h7E).
// The search stops at the first key whose plaintext is fully printable, or when
// the next candidate would pass KEY_LAST.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   en            start a search (sampled only while rdy=1)
//   rdy           idle / accepting en
//   key_valid     last search found a key (valid while rdy=1)
//   key           found key (valid when key_valid=1)
//   a4_en         one-cycle start pulse to the engine
//   a4_rdy        engine idle
//   a4_key        candidate key driven to the engine
//   pt_owner      PT port mux select (1 = controller reads)
//   pt_addr       PT read address
//   pt_rddata     PT read data, one cycle after pt_addr
//
// pt_owner and pt_addr are combinational: the next PT read has to be issued in
// the same cycle the engine reports done or the current byte is judged, so
// that one byte is checked per cycle and no address beyond the first bad byte
// (or beyond L) is ever read.
module arc4_crack_ctrl #(
  parameter int unsigned      KEY_W     = 24,
  parameter logic [KEY_W-1:0] KEY_START = '0,
  parameter logic [KEY_W-1:0] KEY_STEP  = KEY_W'(1),
  parameter logic [KEY_W-1:0] KEY_LAST  = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             rdy,
  output logic             key_valid,
  output logic [KEY_W-1:0] key,
  output logic             a4_en,
  input  logic             a4_rdy,
  output logic [KEY_W-1:0] a4_key,
  output logic             pt_owner,
  output logic [7:0]       pt_addr,
  input  logic [7:0]       pt_rddata
);

  // Candidate counter is one bit wider than the key so cand+KEY_STEP never wraps.
  localparam int unsigned CW = KEY_W + 1;
  localparam int unsigned AW = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SETTLE,
    RUN,
    LEN,
    SCAN,
    HIT,
    MISS
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cand_q, cand_d;
  logic [AW-1:0]    len_q, len_d;
  logic [AW-1:0]    addr_q;
  logic             rdy_q, rdy_d;
  logic             key_valid_q, key_valid_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             a4_en_q, a4_en_d;
  logic [KEY_W-1:0] a4_key_q, a4_key_d;

  logic             byte_ok;
  logic [CW-1:0]    next_cand;

  assign byte_ok   = (pt_rddata >= 8'h20) && (pt_rddata <= 8'h7E);
  assign next_cand = cand_q + CW'(KEY_STEP);

  assign rdy       = rdy_q;
  assign key_valid = key_valid_q;
  assign key       = key_q;
  assign a4_en     = a4_en_q;
  assign a4_key    = a4_key_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cand_q      <= CW'(KEY_START);
      len_q       <= '0;
      addr_q      <= '0;
      rdy_q       <= 1'b1;
      key_valid_q <= 1'b0;
      key_q       <= '0;
      a4_en_q     <= 1'b0;
      a4_key_q    <= KEY_START;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      len_q       <= len_d;
      addr_q      <= pt_addr;
      rdy_q       <= rdy_d;
      key_valid_q <= key_valid_d;
      key_q       <= key_d;
      a4_en_q     <= a4_en_d;
      a4_key_q    <= a4_key_d;
    end
  end

  // Next-state, next-register values and PT port control.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    len_d       = len_q;
    rdy_d       = rdy_q;
    key_valid_d = key_valid_q;
    key_d       = key_q;
    a4_en_d     = 1'b0;
    a4_key_d    = a4_key_q;
    pt_owner    = 1'b0;
    pt_addr     = '0;

    case (state_q)
      IDLE: begin
        if (en) begin
          cand_d      = CW'(KEY_START);
          a4_key_d    = KEY_START;
          key_valid_d = 1'b0;
          rdy_d       = 1'b0;
          state_d     = START;
        end
      end

      START: begin
        if (a4_rdy) begin
          a4_en_d = 1'b1;
          state_d = SETTLE;
        end
      end

      // Engine still shows rdy=1 while it samples the start pulse.
      SETTLE: begin
        state_d = RUN;
      end

      // Issue the read of pt[0] in the cycle the engine finishes.
      RUN: begin
        if (a4_rdy) begin
          pt_owner = 1'b1;
          pt_addr  = '0;
          state_d  = LEN;
        end
      end

      LEN: begin
        pt_owner = 1'b1;
        len_d    = pt_rddata;
        if (pt_rddata == 8'h00) begin
          pt_addr = '0;
          state_d = HIT;
        end else begin
          pt_addr = 8'd1;
          state_d = SCAN;
        end
      end

      // addr_q is the index of the byte now on pt_rddata; prefetch the next one
      // only while the scan is still going and there is a next one.
      SCAN: begin
        pt_owner = 1'b1;
        if (!byte_ok) begin
          pt_addr = addr_q;
          state_d = MISS;
        end else if (addr_q == len_q) begin
          pt_addr = addr_q;
          state_d = HIT;
        end else begin
          pt_addr = addr_q + 8'd1;
        end
      end

      HIT: begin
        key_d       = cand_q[KEY_W-1:0];
        key_valid_d = 1'b1;
        rdy_d       = 1'b1;
        state_d     = IDLE;
      end

      MISS: begin
        if (next_cand > CW'(KEY_LAST)) begin
          key_valid_d = 1'b0;
          rdy_d       = 1'b1;
          state_d     = IDLE;
        end else begin
          cand_d   = next_cand;
          a4_key_d = next_cand[KEY_W-1:0];
          state_d  = START;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_arc4_crack_ctrl.sv
// Randomized self-checking bench for arc4_crack_ctrl. Two controllers: one with
// default key range, one with KEY_START=1, KEY_STEP=2, KEY_LAST=7. Each has a
// behavioural ARC4 engine stand-in and a synchronous PT RAM.
module tb_arc4_crack_ctrl;

  localparam int unsigned KEY_W = 24;
  localparam int          NTBL  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic             en, rdy, key_valid, a4_en, a4_rdy, pt_owner;
  logic [KEY_W-1:0] key, a4_key;
  logic [7:0]       pt_addr, pt_rddata;

  logic             en_s, rdy_s, key_valid_s, a4_en_s, a4_rdy_s, pt_owner_s;
  logic [KEY_W-1:0] key_s, a4_key_s;
  logic [7:0]       pt_addr_s, pt_rddata_s;

  logic [7:0] msg_tbl [NTBL][256];
  logic [7:0] pt_mem  [256];

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_viol = 0;

  arc4_crack_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key_valid(key_valid), .key(key),
    .a4_en(a4_en), .a4_rdy(a4_rdy), .a4_key(a4_key), .pt_owner(pt_owner),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata)
  );

  arc4_crack_ctrl #(.KEY_W(KEY_W), .KEY_START(24'd1), .KEY_STEP(24'd2), .KEY_LAST(24'd7)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .en(en_s), .rdy(rdy_s), .key_valid(key_valid_s), .key(key_s),
    .a4_en(a4_en_s), .a4_rdy(a4_rdy_s), .a4_key(a4_key_s), .pt_owner(pt_owner_s),
    .pt_addr(pt_addr_s), .pt_rddata(pt_rddata_s)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] msg_of(input logic [KEY_W-1:0] k, input int i);
    if (int'(k) < NTBL) return msg_tbl[int'(k)][i];
    return (i == 0) ? 8'd1 : 8'd0;
  endfunction

  function automatic bit printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  // Highest PT address the controller should read for key k.
  function automatic int scan_end(input logic [KEY_W-1:0] k);
    int len;
    len = int'(msg_of(k, 0));
    for (int i = 1; i <= len; i++)
      if (!printable(msg_of(k, i))) return i;
    return len;
  endfunction

  function automatic bit msg_ok(input logic [KEY_W-1:0] k);
    int len;
    len = int'(msg_of(k, 0));
    for (int i = 1; i <= len; i++)
      if (!printable(msg_of(k, i))) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- engine stand-ins and PT RAMs ----------------
  int eng_lat = 3;
  bit hold    = 1'b0;
  bit busy, busy_s;
  int cnt, cnt_s;

  assign a4_rdy   = !busy && !hold;
  assign a4_rdy_s = !busy_s;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= 0;
    end else if (busy) begin
      if (cnt == 0) busy <= 1'b0;
      else          cnt  <= cnt - 1;
    end else if (a4_en && a4_rdy) begin
      busy <= 1'b1;
      cnt  <= eng_lat;
      for (int i = 0; i < 256; i++) pt_mem[i] <= msg_of(a4_key, i);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_s <= 1'b0;
      cnt_s  <= 0;
    end else if (busy_s) begin
      if (cnt_s == 0) busy_s <= 1'b0;
      else            cnt_s  <= cnt_s - 1;
    end else if (a4_en_s && a4_rdy_s) begin
      busy_s <= 1'b1;
      cnt_s  <= 2;
    end
  end

  always @(posedge clk) pt_rddata <= pt_owner ? pt_mem[pt_addr] : 8'($urandom);
  // Stride controller always decrypts to {1, 8'h00}.
  always @(posedge clk) pt_rddata_s <= pt_owner_s ? ((pt_addr_s == 8'd0) ? 8'd1 : 8'd0) : 8'($urandom);

  // ---------------- monitors ----------------
  logic [KEY_W-1:0] keys_q[$];
  logic [KEY_W-1:0] keys_s_q[$];
  int max_addr   [NTBL];
  int max_addr_s [8];
  logic a4_en_prev = 1'b0, a4_en_s_prev = 1'b0;

  always @(negedge clk) begin
    if (a4_en) keys_q.push_back(a4_key);
    if (a4_en_s) keys_s_q.push_back(a4_key_s);
    if (a4_en && (a4_en_prev || !a4_rdy)) n_viol++;
    if (a4_en_s && (a4_en_s_prev || !a4_rdy_s)) n_viol++;
    if (pt_owner && !a4_rdy) n_viol++;
    if (pt_owner_s && !a4_rdy_s) n_viol++;
    if (pt_owner) begin
      if (pt_addr > pt_mem[0]) n_viol++;
      if (int'(a4_key) < NTBL && int'(pt_addr) > max_addr[int'(a4_key)]) max_addr[int'(a4_key)] = int'(pt_addr);
    end
    if (pt_owner_s) begin
      if (pt_addr_s > 8'd1) n_viol++;
      if (int'(a4_key_s) < 8 && int'(pt_addr_s) > max_addr_s[int'(a4_key_s)]) max_addr_s[int'(a4_key_s)] = int'(pt_addr_s);
    end
    a4_en_prev   = a4_en;
    a4_en_s_prev = a4_en_s;
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_msg(input int k, input string body);
    msg_tbl[k][0] = 8'(body.len());
    for (int i = 0; i < body.len(); i++) msg_tbl[k][i+1] = body[i];
  endtask

  task automatic fill_rand(input int k, input bit good);
    int len, bad;
    if (good) begin
      case ($urandom_range(0, 7))
        0:       len = 0;
        1:       len = 255;
        default: len = $urandom_range(1, 60);
      endcase
    end else begin
      len = $urandom_range(1, 40);
    end
    msg_tbl[k][0] = 8'(len);
    for (int i = 1; i <= len; i++) msg_tbl[k][i] = 8'($urandom_range(32, 126));
    if (!good) begin
      bad = $urandom_range(1, len);
      msg_tbl[k][bad] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(127, 255));
    end
  endtask

  task automatic pulse_en();
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
  endtask

  // Full search on the default-range controller, checked against the model.
  task automatic run_search(input string tag, input bit poke_en, input int hold_cycles);
    logic [KEY_W-1:0] exp_keys[$];
    bit               exp_found;
    logic [KEY_W-1:0] exp_key;
    bit               poked;
    int               t;
    exp_found = 1'b0;
    exp_key   = '0;
    poked     = 1'b0;
    for (int k = 0; k < NTBL; k++) begin
      exp_keys.push_back(KEY_W'(k));
      if (msg_ok(KEY_W'(k))) begin
        exp_found = 1'b1;
        exp_key   = KEY_W'(k);
        break;
      end
    end
    keys_q.delete();
    for (int k = 0; k < NTBL; k++) max_addr[k] = -1;
    eng_lat = $urandom_range(1, 6);
    hold    = (hold_cycles > 0);
    pulse_en();
    check({tag, "_busy"}, 32'(rdy), 32'd0);
    if (hold_cycles > 0) begin
      repeat (hold_cycles) @(negedge clk);
      check({tag, "_no_en_while_held"}, 32'(keys_q.size()), 32'd0);
      hold = 1'b0;
    end
    t = 0;
    while (!rdy && t < 30000) begin
      @(negedge clk);
      t++;
      if (poke_en && !poked && keys_q.size() == 3 && !a4_rdy) begin
        en    = 1'b1;
        poked = 1'b1;
      end else begin
        en = 1'b0;
      end
    end
    en = 1'b0;
    check({tag, "_done"}, 32'(rdy), 32'd1);
    check({tag, "_key_valid"}, 32'(key_valid), 32'(exp_found));
    check({tag, "_key"}, 32'(key), 32'(exp_key));
    check({tag, "_n_cand"}, 32'(keys_q.size()), 32'(exp_keys.size()));
    for (int i = 0; i < exp_keys.size() && i < keys_q.size(); i++) begin
      check($sformatf("%s_a4_key%0d", tag, i), 32'(keys_q[i]), 32'(exp_keys[i]));
      check($sformatf("%s_max_addr%0d", tag, i), 32'(max_addr[i]), 32'(scan_end(exp_keys[i])));
    end
    repeat (3) @(negedge clk);
    check({tag, "_key_hold"}, 32'(key), 32'(exp_key));
    check({tag, "_kv_hold"}, 32'(key_valid), 32'(exp_found));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    rst_n = 1'b0;
    en    = 1'b0;
    en_s  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rdy", 32'(rdy), 32'd1);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key", 32'(key), 32'd0);
    check("rst_a4_en", 32'(a4_en), 32'd0);
    check("rst_a4_key", 32'(a4_key), 32'd0);
    check("rst_pt_owner", 32'(pt_owner), 32'd0);
    check("rst_pt_addr", 32'(pt_addr), 32'd0);
    check("rst_a4_key_s", 32'(a4_key_s), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Hit on the first key.
    set_msg(0, "abc");
    run_search("hit0", 1'b0, 0);

    // Keys 0..4 fail at byte 1, key 5 passes; en poked while running.
    for (int k = 0; k < 5; k++) begin
      set_msg(k, "xa");
      msg_tbl[k][1] = 8'h19;
    end
    set_msg(5, "ok");
    run_search("rej_acc", 1'b1, 0);

    // Boundary characters.
    set_msg(0, "  ");
    msg_tbl[0][2] = 8'h7F;
    set_msg(1, " ~");
    run_search("bound", 1'b0, 0);

    // Empty message.
    set_msg(0, "");
    run_search("len0", 1'b0, 0);

    // Engine busy in START for 10 cycles.
    set_msg(0, "hi");
    run_search("hold", 1'b0, 10);

    // Reset in the middle of a 255-byte scan, then rerun it.
    msg_tbl[0][0] = 8'd255;
    for (int i = 1; i < 256; i++) msg_tbl[0][i] = 8'h41;
    pulse_en();
    t = 0;
    while (!(pt_owner && pt_addr > 8'd20) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("rst_mid_reach_scan", 32'(pt_owner), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_rdy", 32'(rdy), 32'd1);
    check("rst_mid_a4_en", 32'(a4_en), 32'd0);
    check("rst_mid_pt_owner", 32'(pt_owner), 32'd0);
    check("rst_mid_key_valid", 32'(key_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_search("len255", 1'b0, 0);

    // Randomized searches.
    for (int s = 0; s < 8; s++) begin
      int target;
      target = $urandom_range(0, 9);
      for (int k = 0; k < target; k++) fill_rand(k, 1'b0);
      fill_rand(target, 1'b1);
      run_search($sformatf("rnd%0d", s), 1'b0, 0);
    end

    // Stride controller: every candidate fails, search must exhaust at 7.
    keys_s_q.delete();
    for (int k = 0; k < 8; k++) max_addr_s[k] = -1;
    @(posedge clk); #1 en_s = 1'b1;
    @(posedge clk); #1 en_s = 1'b0;
    t = 0;
    while (!rdy_s && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("stride_done", 32'(rdy_s), 32'd1);
    check("stride_key_valid", 32'(key_valid_s), 32'd0);
    check("stride_n_cand", 32'(keys_s_q.size()), 32'd4);
    begin
      int i;
      i = 0;
      for (int k = 1; k <= 7; k += 2) begin
        if (i < keys_s_q.size()) check($sformatf("stride_a4_key%0d", i), 32'(keys_s_q[i]), 32'(k));
        check($sformatf("stride_max_addr%0d", k), 32'(max_addr_s[k]), 32'd1);
        i++;
      end
    end

    check("protocol_violations", 32'(n_viol), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
